inst_fetch_unit: RTL and testbench

Front-end fetch stage that owns the architectural fetch PC, issues one instruction-word request at a time to the instruction cache, and buffers returned words with their PC and predicted next PC in a small FIFO feeding the instruction decoder/issue logic. It performs static next-PC prediction: JAL is taken, everything else falls through to PC+4. It accepts a redirect from the commit stage on misprediction, discarding queued and in-flight wrong-path fetches.

---
 rtl/inst_fetch_unit.sv | 111 +++++++++++
 tb/tb_inst_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one icache request in flight and queues
// returned words with their PC and static next-PC prediction (JAL taken).
module inst_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        mem_req_valid_out,
  input  logic        mem_req_ready_in,
  output logic [31:0] mem_addr_out,
  input  logic        mem_resp_valid_in,
  input  logic [31:0] mem_resp_inst_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        out_valid_out,
  input  logic        out_ready_in,
  output logic [31:0] out_inst_out,
  output logic [31:0] out_pc_out,
  output logic [31:0] out_pred_pc_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] head_q, tail_q;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pred_mem_q [DEPTH];

  logic          req_fire, push, pop;
  logic [31:0]   jimm, pred;

  assign mem_req_valid_out = (state_q == IDLE) && (count_q < FULL) && !flush_in;
  assign mem_addr_out      = pc_q;
  assign req_fire          = mem_req_valid_out && mem_req_ready_in;

  // A flush blocks both ends of the queue in its cycle.
  assign push = (state_q == WAIT) && mem_resp_valid_in && !flush_in;
  assign pop  = out_valid_out && out_ready_in && !flush_in;

  assign jimm = {{11{mem_resp_inst_in[31]}}, mem_resp_inst_in[31], mem_resp_inst_in[19:12],
                 mem_resp_inst_in[20], mem_resp_inst_in[30:21], 1'b0};
  assign pred = (mem_resp_inst_in[6:0] == 7'b1101111) ? pc_q + jimm : pc_q + 32'd4;

  assign out_valid_out   = (count_q != '0);
  assign out_inst_out    = inst_mem_q[head_q];
  assign out_pc_out      = pc_mem_q[head_q];
  assign out_pred_pc_out = pred_mem_q[head_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (flush_in) begin
      pc_d    = flush_pc_in;
      count_d = '0;
      unique case (state_q)
        WAIT, DROP: state_d = mem_resp_valid_in ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE:    if (req_fire) state_d = WAIT;
        WAIT:    if (mem_resp_valid_in) state_d = IDLE;
        DROP:    if (mem_resp_valid_in) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (push) pc_d = pred;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
        pred_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      if (flush_in) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) begin
          inst_mem_q[tail_q] <= mem_resp_inst_in;
          pc_mem_q[tail_q]   <= pc_q;
          pred_mem_q[tail_q] <= pred;
          tail_q             <= tail_q + 1'b1;
        end
        if (pop) head_q <= head_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: icache/consumer model drives the DUT,
// a reference model of fetch order feeds a scoreboard checked by a monitor.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mem_req_valid_out;
  logic        mem_req_ready_in;
  logic [31:0] mem_addr_out;
  logic        mem_resp_valid_in;
  logic [31:0] mem_resp_inst_in;
  logic        flush_in;
  logic [31:0] flush_pc_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [31:0] out_inst_out;
  logic [31:0] out_pc_out;
  logic [31:0] out_pred_pc_out;

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .mem_req_valid_out(mem_req_valid_out), .mem_req_ready_in(mem_req_ready_in),
    .mem_addr_out(mem_addr_out),
    .mem_resp_valid_in(mem_resp_valid_in), .mem_resp_inst_in(mem_resp_inst_in),
    .flush_in(flush_in), .flush_pc_in(flush_pc_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .out_inst_out(out_inst_out), .out_pc_out(out_pc_out), .out_pred_pc_out(out_pred_pc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] imem [logic [31:0]];
  int unsigned vectors = 0, miscompares = 0, npops = 0;

  int unsigned ready_pct = 100, oready_pct = 100, flush_pct = 0, rst_pml = 0, max_lat = 0;
  bit          hold_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fetch_word(input logic [31:0] addr);
    logic [31:0] w;
    if (!imem.exists(addr)) begin
      w = $urandom();
      if (w[9:7] < 3'd3) w[6:0] = 7'h6F;
      else if (w[6:0] == 7'h6F) w[6:0] = 7'h13;
      imem[addr] = w;
    end
    return imem[addr];
  endfunction

  // J-immediate assembled arithmetically from its fields, signed by bit 31.
  function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] w);
    int off;
    if (w[6:0] != 7'h6F) return pc + 32'd4;
    off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
    if (w[31]) off = off - (1 << 20);
    return pc + 32'(off);
  endfunction

  // Environment: icache with random latency and random handshakes.
  initial begin : driver
    bit          fire, was_resp, was_rst, pend;
    logic [31:0] addr_n, paddr;
    int unsigned lat;
    rst_in = 1'b1; mem_req_ready_in = 1'b0; mem_resp_valid_in = 1'b0;
    mem_resp_inst_in = '0; flush_in = 1'b0; flush_pc_in = '0; out_ready_in = 1'b0;
    pend = 1'b0; lat = 0; paddr = '0;
    forever begin
      @(negedge clk_in);
      fire     = mem_req_valid_out && mem_req_ready_in;
      addr_n   = mem_addr_out;
      was_resp = mem_resp_valid_in;
      was_rst  = rst_in;
      @(posedge clk_in);
      #1;
      if (was_rst) pend = 1'b0;
      else begin
        if (was_resp) pend = 1'b0;
        if (fire) begin
          pend  = 1'b1;
          paddr = addr_n;
          lat   = $urandom_range(0, max_lat);
        end
      end
      rst_in            = hold_rst || ($urandom_range(0, 999) < rst_pml);
      mem_req_ready_in  = $urandom_range(0, 99) < ready_pct;
      out_ready_in      = $urandom_range(0, 99) < oready_pct;
      flush_in          = $urandom_range(0, 99) < flush_pct;
      flush_pc_in       = $urandom() & 32'h0000_FFFC;
      mem_resp_valid_in = 1'b0;
      mem_resp_inst_in  = $urandom();
      if (pend && !was_rst) begin
        if (lat == 0) begin
          mem_resp_valid_in = 1'b1;
          mem_resp_inst_in  = fetch_word(paddr);
        end else lat--;
      end
    end
  end

  // Reference model of the fetch stream plus scoreboard checks.
  initial begin : monitor
    logic [31:0] m_pc;
    bit          outstanding, wrong_path, after_rst, exp_req;
    entry_t      e;
    m_pc = RESET_PC; outstanding = 0; wrong_path = 0; after_rst = 0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        sb.delete();
        m_pc = RESET_PC; outstanding = 0; wrong_path = 0; after_rst = 1;
        continue;
      end
      if (after_rst) begin
        check("rst_out_inst", out_inst_out, '0);
        check("rst_out_pc", out_pc_out, '0);
        check("rst_out_pred", out_pred_pc_out, '0);
        after_rst = 0;
      end
      exp_req = !outstanding && (sb.size() < DEPTH) && !flush_in;
      check("mem_req_valid", 32'(mem_req_valid_out), 32'(exp_req));
      if (exp_req) check("mem_addr", mem_addr_out, m_pc);
      check("out_valid", 32'(out_valid_out), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("out_inst", out_inst_out, sb[0].inst);
        check("out_pc", out_pc_out, sb[0].pc);
        check("out_pred_pc", out_pred_pc_out, sb[0].pred);
      end
      if (flush_in) begin
        sb.delete();
        m_pc = flush_pc_in;
        if (outstanding) begin
          if (mem_resp_valid_in) begin outstanding = 0; wrong_path = 0; end
          else wrong_path = 1;
        end
      end else begin
        if (sb.size() != 0 && out_ready_in) begin
          void'(sb.pop_front());
          npops++;
        end
        if (outstanding && mem_resp_valid_in) begin
          if (!wrong_path) begin
            e.inst = mem_resp_inst_in;
            e.pc   = m_pc;
            e.pred = ref_pred(m_pc, mem_resp_inst_in);
            sb.push_back(e);
            m_pc = e.pred;
          end
          outstanding = 0;
          wrong_path  = 0;
        end
        if (exp_req && mem_req_ready_in) begin
          outstanding = 1;
          wrong_path  = 0;
        end
      end
    end
  end

  initial begin : main
    for (int unsigned a = 0; a < 16; a += 4) imem[a] = 32'h0000_0013;
    imem[32'h10] = 32'h0100_006F;
    repeat (3) @(posedge clk_in);
    hold_rst = 1'b0;
    repeat (20) @(posedge clk_in);
    hold_rst = 1'b1;
    imem[32'h0] = 32'hFFDF_F06F;
    repeat (2) @(posedge clk_in);
    hold_rst = 1'b0;
    repeat (8) @(posedge clk_in);
    oready_pct = 0;
    repeat (20) @(posedge clk_in);
    oready_pct = 15;
    repeat (150) @(posedge clk_in);
    ready_pct = 70; oready_pct = 60; flush_pct = 8; max_lat = 3; rst_pml = 3;
    repeat (4000) @(posedge clk_in);
    flush_pct = 25; max_lat = 1;
    repeat (1000) @(posedge clk_in);
    @(negedge clk_in);
    check("pops_seen", 32'(npops > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
